// File: rtl/dct_2d_if.sv
// ============================================================================
// Module   : dct_2d_if
// Purpose  : Row input, shared 1-D DCT datapath and column output handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dct_2d_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_row;
   logic [63:0] dct_in;
   logic [63:0] dct_out;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_col;
   logic [2:0]  out_idx;
   logic        out_last;
   logic        busy;

   modport slave (
      input  in_valid, in_row, dct_out, out_ready,
      output in_ready, dct_in, out_valid, out_col, out_idx, out_last, busy
   );

   modport master (
      output in_valid, in_row, dct_out, out_ready,
      input  in_ready, dct_in, out_valid, out_col, out_idx, out_last, busy
   );
endinterface

`default_nettype wire

// File: rtl/dct_2d.sv
// ============================================================================
// Module   : dct_2d_ctrl
// Purpose  : 8x8 2-D DCT sequencer: row pass into a transpose buffer, then
//            a column pass, both through one shared external 1-D DCT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dct_2d_ctrl (
   input  logic    clk,
   input  logic    rst_n,
   dct_2d_if.slave bus
);
   localparam logic [0:0] S_ROW = 1'b0;
   localparam logic [0:0] S_COL = 1'b1;

   logic [0:0]  state;
   logic [63:0] tbuf [0:7];
   logic [2:0]  rcnt;
   logic [2:0]  ccnt;
   logic        col_valid;
   logic [63:0] col_data;
   logic [2:0]  col_idx;

   logic        row_fire;
   logic        col_load;
   logic [63:0] col_vec;

   assign row_fire = (state == S_ROW) && bus.in_valid;
   assign col_load = (state == S_COL) && (!col_valid || bus.out_ready);

   // Transpose read: byte ccnt of every buffered row, row 0 in the top byte.
   always_comb begin
      col_vec = '0;
      for (int r = 0; r < 8; r++) begin
         col_vec[63-8*r -: 8] = tbuf[r][{~ccnt, 3'b000} +: 8];
      end
   end

   assign bus.in_ready  = (state == S_ROW);
   assign bus.dct_in    = (state == S_COL) ? col_vec : bus.in_row;
   assign bus.out_valid = col_valid;
   assign bus.out_col   = col_data;
   assign bus.out_idx   = col_idx;
   assign bus.out_last  = col_valid && (col_idx == 3'd7);
   assign bus.busy      = (state == S_COL) || (rcnt != 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_ROW;
         rcnt      <= 3'd0;
         ccnt      <= 3'd0;
         col_valid <= 1'b0;
         col_data  <= 64'd0;
         col_idx   <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            tbuf[i] <= 64'd0;
         end
      end else begin
         if (row_fire) begin
            tbuf[rcnt] <= bus.dct_out;
            rcnt       <= rcnt + 3'd1;
            if (rcnt == 3'd7) begin
               ccnt  <= 3'd0;
               state <= S_COL;
            end
         end

         // A load overrides the drain so a back-to-back column keeps valid high.
         if (col_load) begin
            col_data  <= bus.dct_out;
            col_idx   <= ccnt;
            col_valid <= 1'b1;
            ccnt      <= ccnt + 3'd1;
            if (ccnt == 3'd7) begin
               state <= S_ROW;
            end
         end else if (col_valid && bus.out_ready) begin
            col_valid <= 1'b0;
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_dct_2d_ctrl.sv
// ============================================================================
// Module   : tb_dct_2d_ctrl
// Purpose  : Scoreboard bench for dct_2d_ctrl with an integer 1-D DCT model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dct_2d_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dct_2d_if bus ();

   dct_2d_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  idx;
      logic [63:0] col;
   } exp_t;

   exp_t        exp_q [$];
   int          col0_cyc [$];
   int          vectors = 0;
   int          miscompares = 0;
   int          pops = 0;
   int          cyc = 0;
   int          run = 0;
   int          last_run = 0;
   logic [63:0] blk [8];

   // Integer DCT-II: DC weight 1448 (=2048/sqrt2), AC weights 2048*cos, >>>15.
   function automatic int cos_tab(input int m);
      case (m)
         0: return 2048;
         1: return 2009;
         2: return 1892;
         3: return 1703;
         4: return 1448;
         5: return 1138;
         6: return 784;
         7: return 400;
         default: return 0;
      endcase
   endfunction

   function automatic int coef(input int k, input int n);
      int m;
      if (k == 0) return 1448;
      m = ((2 * n + 1) * k) % 32;
      if (m > 16) m = 32 - m;
      if (m < 8) return cos_tab(m);
      if (m == 8) return 0;
      return -cos_tab(16 - m);
   endfunction

   function automatic logic [63:0] dct1d(input logic [63:0] x);
      logic [63:0] y;
      int acc;
      int s;
      y = '0;
      for (int k = 0; k < 8; k++) begin
         acc = 0;
         for (int n = 0; n < 8; n++) begin
            acc += int'(x[63-8*n -: 8]) * coef(k, n);
         end
         s = acc >>> 15;
         y[63-8*k -: 8] = s[7:0];
      end
      return y;
   endfunction

   assign bus.dct_out = dct1d(bus.dct_in);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!bus.in_ready) run <= run + 1;
      else if (run != 0) begin
         last_run <= run;
         run      <= 0;
      end
   end

   // Monitor: every accepted column is popped against the head of the queue.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            timeout("unexpected_column");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("col_data", bus.out_col, e.col);
            check("col_idx", {61'd0, bus.out_idx}, {61'd0, e.idx});
            check("col_last", {63'd0, bus.out_last}, {63'd0, (e.idx == 3'd7)});
            pops++;
            if (e.idx == 3'd0) col0_cyc.push_back(cyc);
         end
      end
   end

   task automatic push_hand(input logic [63:0] c0);
      exp_q.push_back('{idx: 3'd0, col: c0});
      for (int c = 1; c < 8; c++) exp_q.push_back('{idx: 3'(c), col: 64'd0});
   endtask

   task automatic push_model();
      logic [63:0] t [8];
      logic [63:0] v;
      for (int r = 0; r < 8; r++) t[r] = dct1d(blk[r]);
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < 8; r++) v[63-8*r -: 8] = t[r][63-8*c -: 8];
         exp_q.push_back('{idx: 3'(c), col: dct1d(v)});
      end
   endtask

   task automatic send_row(input logic [63:0] row);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_row   = row;
      @(negedge clk);
      while (!bus.in_ready && guard < 64) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 64) timeout("row_accept");
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input int nrows, input bit keep_valid);
      for (int r = 0; r < nrows; r++) send_row(blk[r]);
      if (!keep_valid) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         guard++;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) timeout("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idx(input logic [2:0] idx);
      int guard;
      guard = 0;
      while (!(bus.out_valid && bus.out_idx == idx) && guard < 64) begin
         guard++;
         @(posedge clk);
         #1;
      end
      if (guard >= 64) timeout("wait_idx");
   endtask

   task automatic fill_pattern(input int seed);
      for (int r = 0; r < 8; r++)
         for (int n = 0; n < 8; n++)
            blk[r][63-8*n -: 8] = 8'((r * 29 + n * 13 + seed * 7) ^ (n * r));
   endtask

   task automatic directed_block(input logic [63:0] pix, input logic [63:0] colin,
                                 input logic [63:0] c0);
      for (int r = 0; r < 8; r++) blk[r] = pix;
      push_hand(c0);
      send_block(8, 1'b0);
      check("col0_operand", bus.dct_in, colin);
      check("busy_col", {63'd0, bus.busy}, 64'd1);
      check("ready_low_col", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk);
      #1;
      check("col0_latency_valid", {63'd0, bus.out_valid}, 64'd1);
      check("col0_latency_idx", {61'd0, bus.out_idx}, 64'd0);
      drain();
      check("in_ready_gap", 64'(last_run), 64'd8);
   endtask

   initial begin
      int base;
      int t0;
      bus.in_valid  = 1'b0;
      bus.in_row    = 64'h0123456789ABCDEF;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_out_last", {63'd0, bus.out_last}, 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_dct_in", bus.dct_in, 64'h0123456789ABCDEF);
      check("rst_out_col", bus.out_col, 64'd0);
      check("rst_out_idx", {61'd0, bus.out_idx}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mid-grey and white blocks: DC only.
      directed_block(64'h8080808080808080, 64'h2D2D2D2D2D2D2D2D, 64'h0F00000000000000);
      directed_block(64'hFFFFFFFFFFFFFFFF, 64'h5A5A5A5A5A5A5A5A, 64'h1F00000000000000);

      // Backpressure on column 3.
      fill_pattern(1);
      push_model();
      base = pops;
      send_block(8, 1'b0);
      wait_idx(3'd2);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
         check("stall_idx", {61'd0, bus.out_idx}, 64'd3);
         check("stall_col", bus.out_col, exp_q.size() != 0 ? exp_q[0].col : 64'hX);
         if (i < 5) begin
            @(posedge clk);
            #1;
         end
      end
      bus.out_ready = 1'b1;
      drain();
      check("stall_col_count", 64'(pops - base), 64'd8);

      // in_valid held through the column pass, then a back-to-back block.
      fill_pattern(2);
      push_model();
      send_block(8, 1'b1);
      fill_pattern(3);
      push_model();
      send_block(8, 1'b0);
      drain();
      check("held_valid_gap", 64'(last_run), 64'd8);
      if (col0_cyc.size() >= 2)
         check("block_period", 64'(col0_cyc[col0_cyc.size()-1] - col0_cyc[col0_cyc.size()-2]), 64'd16);
      else
         timeout("block_period");

      // Next block accepted while column 7 waits on the sink.
      fill_pattern(4);
      push_model();
      send_block(8, 1'b0);
      wait_idx(3'd6);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      fill_pattern(5);
      push_model();
      t0 = cyc;
      send_block(8, 1'b0);
      check("rows_during_hold", 64'(cyc - t0), 64'd8);
      check("hold7_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold7_idx", {61'd0, bus.out_idx}, 64'd7);
      check("hold7_last", {63'd0, bus.out_last}, 64'd1);
      bus.out_ready = 1'b1;
      drain();

      // Reset after five rows discards the partial block.
      fill_pattern(6);
      send_block(5, 1'b0);
      check("partial_busy", {63'd0, bus.busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
      check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      base = pops;
      fill_pattern(7);
      push_model();
      send_block(8, 1'b0);
      drain();
      check("post_rst_col_count", 64'(pops - base), 64'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire
